// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro used by instr_fetch: INSTR_FETCH_CNT_EN.
package fetch_pkg;

   localparam int INSTR_W = 32;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } fetch_state_t;

   // Opcodes the fetch stage cares about when forming the next PC
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC computation: jump target, taken branch or pc+4.
// Jump wins over branch; all arithmetic wraps modulo 2^WIDTH.
module pc_next_logic
   import fetch_pkg::*;
#(
   parameter int WIDTH = INSTR_W
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [25:0]      instr_idx,
   input  logic             branch,
   input  logic             zero,
   input  logic             jump,
   output logic [WIDTH-1:0] pc_next
);

   logic        [WIDTH-1:0] pc4;
   logic signed [WIDTH-1:0] br_off;

   // Sign-extended word offset of the branch immediate, scaled to bytes
   function automatic logic signed [WIDTH-1:0] branch_offset(input logic [15:0] imm);
      branch_offset = {{(WIDTH-18){imm[15]}}, imm, 2'b00};
   endfunction

   // Select jump target, taken-branch target or sequential address
   always_comb begin
      pc4    = pc + WIDTH'(4);
      br_off = branch_offset(instr_idx[15:0]);
      if (jump) begin
         pc_next = {pc4[WIDTH-1:28], instr_idx, 2'b00};
      end else if (branch && zero) begin
         pc_next = pc4 + br_off;
      end else begin
         pc_next = pc4;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, imem req/ready handshake and
// instruction holding register for the single-cycle MIPS core.
// Optional: define INSTR_FETCH_CNT_EN to add the fetch_cnt output, a
// free-running count of accepted instructions.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = INSTR_W,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   input  logic             instr_accept,
   output logic [5:0]       op,
   output logic [5:0]       funct,
   output logic [WIDTH-1:0] pc,
   input  logic             branch,
   input  logic             zero,
   input  logic             jump
`ifdef INSTR_FETCH_CNT_EN
   ,
   output logic [31:0]      fetch_cnt
`endif
);

   fetch_state_t     state, state_nxt;
   logic             load_instr;
   logic             load_pc;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] instr_q;
   logic [WIDTH-1:0] pc_next;

   pc_next_logic #(.WIDTH(WIDTH)) u_pc_next (
      .pc        (pc_q),
      .instr_idx (instr_q[25:0]),
      .branch    (branch),
      .zero      (zero),
      .jump      (jump),
      .pc_next   (pc_next)
   );

   // State register; reset abandons any outstanding request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and register load strobes; handshakes only count in their own state
   always_comb begin
      state_nxt  = state;
      load_instr = 1'b0;
      load_pc    = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = REQ;
         end
         REQ: begin
            if (imem_ready) begin
               load_instr = 1'b1;
               state_nxt  = VALID;
            end
         end
         VALID: begin
            if (instr_accept) begin
               load_pc   = 1'b1;
               state_nxt = REQ;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Instruction holding register, captured on the memory response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
      end else if (load_instr) begin
         instr_q <= imem_rdata;
      end
   end

   // Program counter, advanced only when the held instruction is executed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (load_pc) begin
         pc_q <= pc_next;
      end
   end

`ifdef INSTR_FETCH_CNT_EN
   logic [31:0] cnt_q;

   // Accepted-instruction counter, wraps at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_pc) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign fetch_cnt = cnt_q;
`endif

   assign imem_req    = (state == REQ);
   assign instr_valid = (state == VALID);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign op          = instr_q[31:26];
   assign funct       = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: three instances share stimulus and differ
// only in RESET_PC so the high-address jump and the PC wrap can be reached.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_accept;
   logic        branch;
   logic        zero;
   logic        jump;

   logic        a_req, b_req, c_req;
   logic [31:0] a_addr, b_addr, c_addr;
   logic [31:0] a_instr, b_instr, c_instr;
   logic        a_valid, b_valid, c_valid;
   logic [5:0]  a_op, b_op, c_op;
   logic [5:0]  a_funct, b_funct, c_funct;
   logic [31:0] a_pc, b_pc, c_pc;
`ifdef INSTR_FETCH_CNT_EN
   logic [31:0] a_cnt, b_cnt, c_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instr_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u_a (
      .clk(clk), .rst_n(rst_n), .imem_req(a_req), .imem_addr(a_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(a_instr),
      .instr_valid(a_valid), .instr_accept(instr_accept), .op(a_op),
      .funct(a_funct), .pc(a_pc), .branch(branch), .zero(zero), .jump(jump)
`ifdef INSTR_FETCH_CNT_EN
      , .fetch_cnt(a_cnt)
`endif
   );

   instr_fetch #(.WIDTH(32), .RESET_PC(32'h0FFF_FFFC)) u_b (
      .clk(clk), .rst_n(rst_n), .imem_req(b_req), .imem_addr(b_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(b_instr),
      .instr_valid(b_valid), .instr_accept(instr_accept), .op(b_op),
      .funct(b_funct), .pc(b_pc), .branch(branch), .zero(zero), .jump(jump)
`ifdef INSTR_FETCH_CNT_EN
      , .fetch_cnt(b_cnt)
`endif
   );

   instr_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_c (
      .clk(clk), .rst_n(rst_n), .imem_req(c_req), .imem_addr(c_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(c_instr),
      .instr_valid(c_valid), .instr_accept(instr_accept), .op(c_op),
      .funct(c_funct), .pc(c_pc), .branch(branch), .zero(zero), .jump(jump)
`ifdef INSTR_FETCH_CNT_EN
      , .fetch_cnt(c_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      imem_ready   = 1'b0;
      imem_rdata   = 32'h0;
      instr_accept = 1'b0;
      branch       = 1'b0;
      zero         = 1'b0;
      jump         = 1'b0;
      step();
      step();

      // Reset values
      chk("rst_pc",    a_pc, 32'h0);
      chk("rst_addr",  a_addr, 32'h0);
      chk("rst_instr", a_instr, 32'h0);
      chk("rst_op",    32'(a_op), 32'h0);
      chk("rst_funct", 32'(a_funct), 32'h0);
      chk("rst_valid", 32'(a_valid), 32'h0);
      chk("rst_req",   32'(a_req), 32'h0);
      chk("rst_b_pc",  b_pc, 32'h0FFF_FFFC);
`ifdef INSTR_FETCH_CNT_EN
      chk("rst_cnt",   a_cnt, 32'h0);
`endif

      // Release reset; zero-wait memory returns addi
      rst_n      = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = 32'h2008_0005;
      chk("idle_req", 32'(a_req), 32'h0);
      step();
      chk("c1_req",   32'(a_req), 32'h1);
      chk("c1_addr",  a_addr, 32'h0);
      chk("c1_valid", 32'(a_valid), 32'h0);
      step();
      chk("c2_valid", 32'(a_valid), 32'h1);
      chk("c2_req",   32'(a_req), 32'h0);
      chk("c2_instr", a_instr, 32'h2008_0005);
      chk("c2_op",    32'(a_op), 32'h08);
      chk("c2_funct", 32'(a_funct), 32'h05);
      imem_ready   = 1'b0;
      instr_accept = 1'b1;
      step();
      instr_accept = 1'b0;
      chk("acc_pc",   a_pc, 32'h4);
      chk("acc_req",  32'(a_req), 32'h1);
      chk("acc_addr", a_addr, 32'h4);
      chk("b_seq_pc", b_pc, 32'h1000_0000);
      chk("c_wrap",   c_pc, 32'h0);

      // Three wait cycles; a stray accept+jump in REQ must not move the PC
      instr_accept = 1'b1;
      jump         = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("wait_req",  32'(a_req), 32'h1);
         chk("wait_addr", a_addr, 32'h4);
         step();
      end
      instr_accept = 1'b0;
      jump         = 1'b0;
      chk("wait_req4",  32'(a_req), 32'h1);
      chk("wait_valid", 32'(a_valid), 32'h0);
      chk("wait_pc",    a_pc, 32'h4);
      imem_ready = 1'b1;
      imem_rdata = 32'h0800_0010;
      step();
      chk("j_valid", 32'(a_valid), 32'h1);
      chk("j_instr", a_instr, 32'h0800_0010);

      // Withhold accept; late ready/new rdata in VALID are ignored
      imem_rdata = 32'hDEAD_BEEF;
      branch     = 1'b1;
      zero       = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(a_valid), 32'h1);
         chk("hold_req",   32'(a_req), 32'h0);
         chk("hold_pc",    a_pc, 32'h4);
         chk("hold_instr", a_instr, 32'h0800_0010);
         step();
      end
      imem_ready = 1'b0;

      // Jump together with taken branch: jump wins
      instr_accept = 1'b1;
      jump         = 1'b1;
      step();
      instr_accept = 1'b0;
      jump         = 1'b0;
      branch       = 1'b0;
      zero         = 1'b0;
      chk("jump_pc",   a_pc, 32'h40);
      chk("b_jump_pc", b_pc, 32'h1000_0040);

      // Taken beq at 0x40 with offset -2
      imem_ready = 1'b1;
      imem_rdata = 32'h1000_FFFE;
      step();
      imem_ready = 1'b0;
      chk("beq_op", 32'(a_op), 32'h04);
      instr_accept = 1'b1;
      branch       = 1'b1;
      zero         = 1'b1;
      step();
      instr_accept = 1'b0;
      branch       = 1'b0;
      zero         = 1'b0;
      chk("beq_taken_pc", a_pc, 32'h3C);

      // Jump back to 0x40
      imem_ready = 1'b1;
      imem_rdata = 32'h0800_0010;
      step();
      imem_ready   = 1'b0;
      instr_accept = 1'b1;
      jump         = 1'b1;
      step();
      instr_accept = 1'b0;
      jump         = 1'b0;
      chk("jback_pc", a_pc, 32'h40);
`ifdef INSTR_FETCH_CNT_EN
      chk("cnt4", a_cnt, 32'h4);
`endif

      // Not-taken beq at 0x40
      imem_ready = 1'b1;
      imem_rdata = 32'h1000_FFFE;
      step();
      imem_ready   = 1'b0;
      instr_accept = 1'b1;
      branch       = 1'b1;
      zero         = 1'b0;
      step();
      instr_accept = 1'b0;
      branch       = 1'b0;
      chk("beq_nt_pc", a_pc, 32'h44);
      chk("beq_nt_req", 32'(a_req), 32'h1);

      // Reset pulse during REQ; ready raised around it must be ignored
      rst_n      = 1'b0;
      imem_ready = 1'b1;
      #1;
      chk("rp_pc",    a_pc, 32'h0);
      chk("rp_req",   32'(a_req), 32'h0);
      chk("rp_valid", 32'(a_valid), 32'h0);
      chk("rp_instr", a_instr, 32'h0);
      chk("rp_op",    32'(a_op), 32'h0);
      step();
      rst_n = 1'b1;
      chk("rp_idle_req", 32'(a_req), 32'h0);
      step();
      imem_ready = 1'b0;
      chk("rp_req1",   32'(a_req), 32'h1);
      chk("rp_valid1", 32'(a_valid), 32'h0);
      chk("rp_instr1", a_instr, 32'h0);
      step();
      chk("rp_req2",   32'(a_req), 32'h1);
      chk("rp_valid2", 32'(a_valid), 32'h0);
`ifdef INSTR_FETCH_CNT_EN
      chk("rp_cnt", a_cnt, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
